// File: rtl/reg_transport_pkg.sv
// Register transport payload shared by the pipeline and the register file.
package reg_transport_pkg;

  localparam int unsigned REG_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH = 5;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]  value;
  } reg_transport_t;

endpackage

// File: rtl/wb_pkg.sv
// Writeback stage types: FSM states and RV32 load funct3 codes.
package wb_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Selects and extends load data from an aligned memory word.
module load_extend
  import wb_pkg::*;
  import reg_transport_pkg::*;
(
  input  logic [REG_WIDTH-1:0] word,
  input  logic [2:0]           funct3,
  input  logic [1:0]           byte_off,
  output logic [REG_WIDTH-1:0] value
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Byte/half selection, then sign or zero extension by funct3
  always_comb begin
    sel_byte = word[8*byte_off +: 8];
    sel_half = byte_off[1] ? word[31:16] : word[15:0];
    value    = word;
    case (funct3)
      LB:      value = {{24{sel_byte[7]}}, sel_byte};
      LBU:     value = {24'h0, sel_byte};
      LH:      value = {{16{sel_half[15]}}, sel_half};
      LHU:     value = {16'h0, sel_half};
      LW:      value = word;
      default: value = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: completes loads and drives the register-file write port.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage
  import wb_pkg::*;
  import reg_transport_pkg::*;
(
  input  logic                 iClk,
  input  logic                 nRst,
  input  logic                 iValid,
  output logic                 oReady,
  input  reg_transport_t       iRd,
  input  logic                 iIsLoad,
  input  logic [2:0]           iFunct3,
  input  logic [1:0]           iByteOff,
  input  logic                 iMemRespValid,
  input  logic [REG_WIDTH-1:0] iMemRData,
  output logic                 oWriteEn,
  output reg_transport_t       oRd,
  output logic                 oFwdValid,
  output logic                 oSpurious,
  output logic [31:0]          oRetireCount
);

  wb_state_t             state;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [2:0]            ld_funct3;
  logic [1:0]            ld_off;
  logic [REG_WIDTH-1:0]  ld_value;
  logic                  accept;
  logic                  retire;

  load_extend u_load_extend (
    .word     (iMemRData),
    .funct3   (ld_funct3),
    .byte_off (ld_off),
    .value    (ld_value)
  );

  // Handshake and retire strobes
  always_comb begin
    accept = iValid & oReady;
    retire = (accept & ~iIsLoad) | ((state == WAIT_LOAD) & iMemRespValid);
  end

  // Writeback FSM with registered write port, ready and spurious flag
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      oReady    <= 1'b0;
      oWriteEn  <= 1'b0;
      oFwdValid <= 1'b0;
      oRd       <= '0;
      oSpurious <= 1'b0;
      ld_addr   <= '0;
      ld_funct3 <= '0;
      ld_off    <= '0;
    end else begin
      oWriteEn  <= 1'b0;
      oFwdValid <= 1'b0;
      case (state)
        IDLE: begin
          oReady <= 1'b1;
          if (iMemRespValid) oSpurious <= 1'b1;
          if (accept) begin
            if (iIsLoad) begin
              ld_addr   <= iRd.addr;
              ld_funct3 <= iFunct3;
              ld_off    <= iByteOff;
              oReady    <= 1'b0;
              state     <= WAIT_LOAD;
            end else begin
              oRd       <= iRd;
              oWriteEn  <= (iRd.addr != '0);
              oFwdValid <= (iRd.addr != '0);
            end
          end
        end
        WAIT_LOAD: begin
          oReady <= 1'b0;
          if (iMemRespValid) begin
            oRd.addr  <= ld_addr;
            oRd.value <= ld_value;
            oWriteEn  <= (ld_addr != '0);
            oFwdValid <= (ld_addr != '0);
            oReady    <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;

  // Free-running retire counter, wraps naturally
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + 32'd1;
  end

  assign oRetireCount = retire_cnt;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign oRetireCount  = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed plan plus random traffic.
module tb_writeback_stage;
  import reg_transport_pkg::*;

  logic           iClk = 1'b0;
  logic           nRst;
  logic           iValid;
  logic           oReady;
  reg_transport_t iRd;
  logic           iIsLoad;
  logic [2:0]     iFunct3;
  logic [1:0]     iByteOff;
  logic           iMemRespValid;
  logic [31:0]    iMemRData;
  logic           oWriteEn;
  reg_transport_t oRd;
  logic           oFwdValid;
  logic           oSpurious;
  logic [31:0]    oRetireCount;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the stage
  bit          m_ready, m_wait, m_spur, m_we;
  logic [4:0]  m_addr, m_rd_addr;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic [31:0] m_rd_val, m_cnt;

  writeback_stage dut (
    .iClk(iClk), .nRst(nRst), .iValid(iValid), .oReady(oReady), .iRd(iRd),
    .iIsLoad(iIsLoad), .iFunct3(iFunct3), .iByteOff(iByteOff),
    .iMemRespValid(iMemRespValid), .iMemRData(iMemRData), .oWriteEn(oWriteEn),
    .oRd(oRd), .oFwdValid(oFwdValid), .oSpurious(oSpurious),
    .oRetireCount(oRetireCount)
  );

  always #5 iClk = ~iClk;

  function automatic logic [31:0] ref_ext(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((w >> (8 * int'(off))) & 32'hFF);
    h = 16'((w >> (16 * int'(off[1]))) & 32'hFFFF);
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b100:  return 32'(b);
      3'b001:  return 32'($signed(h));
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"}, 32'(oReady), 32'(m_ready));
    chk({tag, ".we"}, 32'(oWriteEn), 32'(m_we));
    chk({tag, ".fwd"}, 32'(oFwdValid), 32'(m_we));
    chk({tag, ".addr"}, 32'(oRd.addr), 32'(m_rd_addr));
    chk({tag, ".value"}, oRd.value, m_rd_val);
    chk({tag, ".spur"}, 32'(oSpurious), 32'(m_spur));
`ifdef WB_RETIRE_CNT_EN
    chk({tag, ".cnt"}, oRetireCount, m_cnt);
`else
    chk({tag, ".cnt"}, oRetireCount, 32'd0);
`endif
  endtask

  // Advance one clock with the currently driven inputs, then check
  task automatic cycle(input string tag);
    bit acc;
    m_we = 0;
    if (!m_wait) begin
      acc = iValid && m_ready;
      if (iMemRespValid) m_spur = 1;
      if (acc && iIsLoad) begin
        m_wait = 1; m_addr = iRd.addr; m_f3 = iFunct3; m_off = iByteOff;
      end else if (acc) begin
        m_rd_addr = iRd.addr; m_rd_val = iRd.value; m_we = (iRd.addr != 0); m_cnt++;
      end
    end else if (iMemRespValid) begin
      m_wait = 0; m_rd_addr = m_addr; m_rd_val = ref_ext(iMemRData, m_f3, m_off);
      m_we = (m_addr != 0); m_cnt++;
    end
    m_ready = !m_wait;
    @(posedge iClk); #1;
    check_all(tag);
  endtask

  task automatic idle_in();
    iValid = 0; iIsLoad = 0; iMemRespValid = 0; iFunct3 = 0; iByteOff = 0;
    iRd = '0; iMemRData = 32'h0;
  endtask

  task automatic issue(input logic [4:0] a, input logic [31:0] v, input bit ld,
                       input logic [2:0] f3, input logic [1:0] off);
    idle_in();
    iValid = 1; iRd.addr = a; iRd.value = v; iIsLoad = ld; iFunct3 = f3; iByteOff = off;
  endtask

  task automatic respond(input logic [31:0] d);
    idle_in();
    iMemRespValid = 1; iMemRData = d;
  endtask

  task automatic apply_reset();
    nRst = 0;
    #3;
    m_ready = 0; m_wait = 0; m_spur = 0; m_we = 0; m_rd_addr = 0; m_rd_val = 0; m_cnt = 0;
    check_all("reset");
    nRst = 1;
  endtask

  initial begin
    nRst = 1;
    idle_in();
    #2;
    apply_reset();
    cycle("post_reset");

    // Non-load burst
    issue(5'd5, 32'h11, 0, 3'b0, 2'd0); cycle("burst0");
    chk("burst0.v", oRd.value, 32'h11);
    issue(5'd6, 32'h22, 0, 3'b0, 2'd0); cycle("burst1");
    issue(5'd7, 32'h33, 0, 3'b0, 2'd0); cycle("burst2");
    chk("burst2.we", 32'(oWriteEn), 32'd1);
    idle_in(); cycle("burst_end");

    // LB sign extension after a 4-cycle wait
    issue(5'd3, 32'h0, 1, 3'b000, 2'd2); cycle("lb_acc");
    idle_in();
    for (int i = 0; i < 3; i++) cycle("lb_wait");
    chk("lb_wait.ready", 32'(oReady), 32'd0);
    respond(32'h0080FF00); cycle("lb_resp");
    chk("lb.value", oRd.value, 32'hFFFFFF80);
    chk("lb.addr", 32'(oRd.addr), 32'd3);
    idle_in(); cycle("lb_after");

    // LHU / LH on upper half
    issue(5'd9, 32'h0, 1, 3'b101, 2'd2); cycle("lhu_acc");
    respond(32'h80017F02); cycle("lhu_resp");
    chk("lhu.value", oRd.value, 32'h00008001);
    issue(5'd10, 32'h0, 1, 3'b001, 2'd3); cycle("lh_acc");
    respond(32'h80017F02); cycle("lh_resp");
    chk("lh.value", oRd.value, 32'hFFFF8001);

    // x0 write suppressed, still retires
    issue(5'd0, 32'hDEAD, 0, 3'b0, 2'd0); cycle("x0");
    chk("x0.we", 32'(oWriteEn), 32'd0);
    idle_in(); cycle("x0_after");

    // Spurious response while idle is sticky
    respond(32'h12345678); cycle("spur");
    chk("spur.flag", 32'(oSpurious), 32'd1);
    idle_in(); cycle("spur_hold");

    // Reset mid-wait drops the load; late response is spurious
    issue(5'd4, 32'h0, 1, 3'b010, 2'd0); cycle("rst_acc");
    idle_in(); cycle("rst_wait");
    apply_reset();
    idle_in(); cycle("rst_rel");
    chk("rst_rel.ready", 32'(oReady), 32'd1);
    respond(32'hCAFEF00D); cycle("late_resp");
    chk("late_resp.we", 32'(oWriteEn), 32'd0);
    chk("late_resp.spur", 32'(oSpurious), 32'd1);

`ifdef WB_RETIRE_CNT_EN
    // Counter wrap
    idle_in();
    force dut.retire_cnt = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt;
    m_cnt = 32'hFFFFFFFF;
    issue(5'd1, 32'h1, 0, 3'b0, 2'd0); cycle("wrap");
    chk("wrap.cnt", oRetireCount, 32'h0);
`endif

    // Random traffic against the model
    apply_reset();
    idle_in(); cycle("rand_start");
    for (int i = 0; i < 400; i++) begin
      idle_in();
      iValid        = ($urandom_range(0, 3) != 0);
      iRd.addr      = 5'($urandom_range(0, 31));
      iRd.value     = $urandom;
      iIsLoad       = ($urandom_range(0, 2) == 0);
      iFunct3       = 3'($urandom_range(0, 7));
      iByteOff      = 2'($urandom_range(0, 3));
      iMemRespValid = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0);
      iMemRData     = $urandom;
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
